pipeline_ctrl: RTL and testbench

Central hazard and redirect controller for the five-stage core (IF, ID, EX, MEM, WB). It computes per-register `stall` and `flush` controls for the PC register and the four inter-stage pipeline registers (IF_ID, ID_EX, EX_MEM, MEM_WB). It also sequences exception and branch redirects to the fetch unit with a valid/ready handshake. Every pipeline register takes its `stall`/`flush` inputs only from this block.

---
 rtl/pipeline_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// Hazard and redirect controller for the five-stage core: per-register stall/flush plus fetch redirect handshake.
// Optional performance counters are compiled in with `define PIPE_CTRL_PERF_EN.
module pipeline_ctrl #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_rs1_en,
  input  logic              id_rs2_en,
  input  logic [REG_AW-1:0] id_rs1_addr,
  input  logic [REG_AW-1:0] id_rs2_addr,
  input  logic              ex_is_load,
  input  logic              ex_rw_en,
  input  logic [REG_AW-1:0] ex_rw_addr,
  input  logic              ex_busy,
  input  logic              mem_wait,
  input  logic              ex_br_taken,
  input  logic [ADDR_W-1:0] ex_br_target,
  input  logic              wb_except_valid,
  input  logic [ADDR_W-1:0] wb_except_target,
  output logic [4:0]        stall,
  output logic [4:0]        flush,
  output logic              redirect_valid,
  output logic [ADDR_W-1:0] redirect_pc,
  input  logic              redirect_ready
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_loaduse_cnt,
  output logic [PERF_W-1:0] perf_busy_cnt,
  output logic [PERF_W-1:0] perf_memwait_cnt,
  output logic [PERF_W-1:0] perf_redirect_cnt
`endif
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    EXC_REDIR = 2'd1,
    BR_REDIR  = 2'd2
  } state_e;

  localparam logic [4:0] FL_EXC     = 5'b11110;
  localparam logic [4:0] ST_MEMWAIT = 5'b01111;
  localparam logic [4:0] FL_MEMWAIT = 5'b10000;
  localparam logic [4:0] ST_BUSY    = 5'b00111;
  localparam logic [4:0] FL_BUSY    = 5'b01000;
  localparam logic [4:0] FL_BR      = 5'b00110;
  localparam logic [4:0] ST_BR_HOLD = 5'b11000;
  localparam logic [4:0] ST_LOADUSE = 5'b00011;
  localparam logic [4:0] FL_LOADUSE = 5'b00100;

  if (ADDR_W < 1 || REG_AW < 1 || PERF_W < 1) begin : g_param_check
    $error("pipeline_ctrl: ADDR_W, REG_AW and PERF_W must all be at least 1");
  end

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              load_use;

  // A load into x0 never creates a dependency, so it must not cost a bubble.
  assign load_use = ex_is_load && ex_rw_en && (ex_rw_addr != '0) &&
                    ((id_rs1_en && (id_rs1_addr == ex_rw_addr)) ||
                     (id_rs2_en && (id_rs2_addr == ex_rw_addr)));

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it holding a value (no latch).
    state_d        = state_q;
    pc_d           = pc_q;
    stall          = '0;
    flush          = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;

    unique case (state_q)
      RUN: begin
        if (wb_except_valid) begin
          flush   = FL_EXC;
          pc_d    = wb_except_target;
          state_d = EXC_REDIR;
        end else if (mem_wait) begin
          stall = ST_MEMWAIT;
          flush = FL_MEMWAIT;
        end else if (ex_busy) begin
          stall = ST_BUSY;
          flush = FL_BUSY;
        end else if (ex_br_taken) begin
          flush          = FL_BR;
          redirect_valid = 1'b1;
          redirect_pc    = ex_br_target;
          if (!redirect_ready) begin
            pc_d    = ex_br_target;
            state_d = BR_REDIR;
          end
        end else if (load_use) begin
          stall = ST_LOADUSE;
          flush = FL_LOADUSE;
        end
      end

      EXC_REDIR: begin
        flush          = FL_EXC;
        redirect_valid = 1'b1;
        redirect_pc    = pc_q;
        if (redirect_ready) begin
          state_d = RUN;
        end
      end

      BR_REDIR: begin
        // An exception reaching WB outranks the pending branch and replaces its target.
        if (wb_except_valid) begin
          flush   = FL_EXC;
          pc_d    = wb_except_target;
          state_d = EXC_REDIR;
        end else begin
          flush          = FL_BR;
          stall          = ST_BR_HOLD;
          redirect_valid = 1'b1;
          redirect_pc    = pc_q;
          if (redirect_ready) begin
            state_d = RUN;
          end
        end
      end

      default: begin
        state_d = RUN;
      end
    endcase

    // Reset silences every control at once, before the state register has cleared.
    if (rst) begin
      stall          = '0;
      flush          = '0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    if (rst) begin
      state_q <= RUN;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [PERF_W-1:0] loaduse_cnt_q, loaduse_cnt_d;
  logic [PERF_W-1:0] busy_cnt_q, busy_cnt_d;
  logic [PERF_W-1:0] memwait_cnt_q, memwait_cnt_d;
  logic [PERF_W-1:0] redirect_cnt_q, redirect_cnt_d;
  logic              loaduse_fire, busy_fire, memwait_fire, redirect_fire;

  // Each stall pattern is produced by exactly one rule, so the pattern identifies the rule.
  assign loaduse_fire  = (stall == ST_LOADUSE);
  assign busy_fire     = (stall == ST_BUSY);
  assign memwait_fire  = (stall == ST_MEMWAIT);
  assign redirect_fire = redirect_valid && redirect_ready;

  always_comb begin
    loaduse_cnt_d  = loaduse_cnt_q  + PERF_W'(loaduse_fire);
    busy_cnt_d     = busy_cnt_q     + PERF_W'(busy_fire);
    memwait_cnt_d  = memwait_cnt_q  + PERF_W'(memwait_fire);
    redirect_cnt_d = redirect_cnt_q + PERF_W'(redirect_fire);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      loaduse_cnt_q  <= '0;
      busy_cnt_q     <= '0;
      memwait_cnt_q  <= '0;
      redirect_cnt_q <= '0;
    end else begin
      loaduse_cnt_q  <= loaduse_cnt_d;
      busy_cnt_q     <= busy_cnt_d;
      memwait_cnt_q  <= memwait_cnt_d;
      redirect_cnt_q <= redirect_cnt_d;
    end
  end

  assign perf_loaduse_cnt  = loaduse_cnt_q;
  assign perf_busy_cnt     = busy_cnt_q;
  assign perf_memwait_cnt  = memwait_cnt_q;
  assign perf_redirect_cnt = redirect_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: hazard rules, redirect sequencing, priority and reset behaviour.
// Inputs change just after the falling edge; outputs are sampled 1ns later, well away from the rising edge.
module tb_pipeline_ctrl;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned PERF_W = 32;

  logic              clk;
  logic              rst;
  logic              id_rs1_en, id_rs2_en;
  logic [REG_AW-1:0] id_rs1_addr, id_rs2_addr;
  logic              ex_is_load, ex_rw_en;
  logic [REG_AW-1:0] ex_rw_addr;
  logic              ex_busy, mem_wait, ex_br_taken;
  logic [ADDR_W-1:0] ex_br_target;
  logic              wb_except_valid;
  logic [ADDR_W-1:0] wb_except_target;
  logic [4:0]        stall, flush;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              redirect_ready;
`ifdef PIPE_CTRL_PERF_EN
  logic [PERF_W-1:0] perf_loaduse_cnt, perf_busy_cnt, perf_memwait_cnt, perf_redirect_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  pipeline_ctrl #(
    .ADDR_W(ADDR_W),
    .REG_AW(REG_AW),
    .PERF_W(PERF_W)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .id_rs1_en        (id_rs1_en),
    .id_rs2_en        (id_rs2_en),
    .id_rs1_addr      (id_rs1_addr),
    .id_rs2_addr      (id_rs2_addr),
    .ex_is_load       (ex_is_load),
    .ex_rw_en         (ex_rw_en),
    .ex_rw_addr       (ex_rw_addr),
    .ex_busy          (ex_busy),
    .mem_wait         (mem_wait),
    .ex_br_taken      (ex_br_taken),
    .ex_br_target     (ex_br_target),
    .wb_except_valid  (wb_except_valid),
    .wb_except_target (wb_except_target),
    .stall            (stall),
    .flush            (flush),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .redirect_ready   (redirect_ready)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .perf_loaduse_cnt (perf_loaduse_cnt),
    .perf_busy_cnt    (perf_busy_cnt),
    .perf_memwait_cnt (perf_memwait_cnt),
    .perf_redirect_cnt(perf_redirect_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [4:0] exp_stall, input logic [4:0] exp_flush,
                           input logic exp_valid, input logic [ADDR_W-1:0] exp_pc);
    check({tag, ".stall"}, 64'(stall), 64'(exp_stall));
    check({tag, ".flush"}, 64'(flush), 64'(exp_flush));
    check({tag, ".rvalid"}, 64'(redirect_valid), 64'(exp_valid));
    check({tag, ".rpc"}, 64'(redirect_pc), 64'(exp_pc));
  endtask

  task automatic idle();
    id_rs1_en = 0; id_rs2_en = 0; id_rs1_addr = '0; id_rs2_addr = '0;
    ex_is_load = 0; ex_rw_en = 0; ex_rw_addr = '0;
    ex_busy = 0; mem_wait = 0; ex_br_taken = 0; ex_br_target = '0;
    wb_except_valid = 0; wb_except_target = '0; redirect_ready = 0;
  endtask

  // Advance to the next falling edge; callers then set inputs and wait #1 before sampling.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    #1;
    check_out("reset_hold", 5'b00000, 5'b00000, 1'b0, 32'h0);
    next_cycle();
    rst = 1'b0;
    #1;
    check_out("after_reset", 5'b00000, 5'b00000, 1'b0, 32'h0);

    // Load-use on rs2
    next_cycle(); idle();
    ex_is_load = 1; ex_rw_en = 1; ex_rw_addr = 5'd5; id_rs2_en = 1; id_rs2_addr = 5'd5;
    #1; check_out("loaduse_rs2", 5'b00011, 5'b00100, 1'b0, 32'h0);
    next_cycle();
    ex_rw_addr = 5'd0; id_rs2_addr = 5'd0;
    #1; check_out("loaduse_x0", 5'b00000, 5'b00000, 1'b0, 32'h0);
    next_cycle(); idle();
    ex_is_load = 1; ex_rw_en = 1; ex_rw_addr = 5'd7; id_rs1_en = 0; id_rs1_addr = 5'd7;
    #1; check_out("loaduse_rs1_disabled", 5'b00000, 5'b00000, 1'b0, 32'h0);
    next_cycle(); idle();
    ex_is_load = 1; ex_rw_en = 0; ex_rw_addr = 5'd9; id_rs1_en = 1; id_rs1_addr = 5'd9;
    #1; check_out("loaduse_no_write", 5'b00000, 5'b00000, 1'b0, 32'h0);

    // Divider busy for 8 cycles
    for (int i = 0; i < 8; i++) begin
      next_cycle(); idle(); ex_busy = 1;
      #1; check_out($sformatf("busy_%0d", i), 5'b00111, 5'b01000, 1'b0, 32'h0);
    end
    next_cycle(); idle();
    #1; check_out("busy_done", 5'b00000, 5'b00000, 1'b0, 32'h0);

    // mem_wait outranks ex_busy and a pending branch
    next_cycle(); idle(); mem_wait = 1; ex_busy = 1; ex_br_taken = 1; ex_br_target = 32'h1c000080;
    #1; check_out("memwait_over_busy", 5'b01111, 5'b10000, 1'b0, 32'h0);

    // Branch accepted in the same cycle
    next_cycle(); idle(); ex_br_taken = 1; ex_br_target = 32'h1c000040; redirect_ready = 1;
    #1; check_out("br_ready_now", 5'b00000, 5'b00110, 1'b1, 32'h1c000040);
    next_cycle(); idle();
    #1; check_out("br_ready_after", 5'b00000, 5'b00000, 1'b0, 32'h0);

    // Branch with fetch not ready for 3 cycles; later target changes must not leak out
    next_cycle(); idle(); ex_br_taken = 1; ex_br_target = 32'h1c000100;
    #1; check_out("br_wait_0", 5'b00000, 5'b00110, 1'b1, 32'h1c000100);
    for (int i = 1; i < 3; i++) begin
      next_cycle(); idle(); ex_br_target = 32'hdead0000;
      #1; check_out($sformatf("br_wait_%0d", i), 5'b11000, 5'b00110, 1'b1, 32'h1c000100);
    end
    next_cycle(); idle(); redirect_ready = 1;
    #1; check_out("br_wait_accept", 5'b11000, 5'b00110, 1'b1, 32'h1c000100);
    next_cycle(); idle();
    #1; check_out("br_wait_run", 5'b00000, 5'b00000, 1'b0, 32'h0);

    // Exception over mem_wait
    next_cycle(); idle(); wb_except_valid = 1; wb_except_target = 32'h1c008000; mem_wait = 1;
    #1; check_out("exc_n", 5'b00000, 5'b11110, 1'b0, 32'h0);
    next_cycle(); idle();
    #1; check_out("exc_n1", 5'b00000, 5'b11110, 1'b1, 32'h1c008000);
    next_cycle(); idle(); redirect_ready = 1;
    #1; check_out("exc_n2_accept", 5'b00000, 5'b11110, 1'b1, 32'h1c008000);
    next_cycle(); idle();
    #1; check_out("exc_run", 5'b00000, 5'b00000, 1'b0, 32'h0);

    // Exception while a branch redirect is pending
    next_cycle(); idle(); ex_br_taken = 1; ex_br_target = 32'h1c000200;
    #1; check_out("brx_br", 5'b00000, 5'b00110, 1'b1, 32'h1c000200);
    next_cycle(); idle();
    #1; check_out("brx_hold", 5'b11000, 5'b00110, 1'b1, 32'h1c000200);
    next_cycle(); idle(); wb_except_valid = 1; wb_except_target = 32'h1c00a000;
    #1; check_out("brx_exc", 5'b00000, 5'b11110, 1'b0, 32'h0);
    next_cycle(); idle(); wb_except_valid = 1; wb_except_target = 32'h1c00b000;
    #1; check_out("brx_excredir", 5'b00000, 5'b11110, 1'b1, 32'h1c00a000);
    next_cycle(); idle(); redirect_ready = 1;
    #1; check_out("brx_accept", 5'b00000, 5'b11110, 1'b1, 32'h1c00a000);
    next_cycle(); idle();
    #1; check_out("brx_run", 5'b00000, 5'b00000, 1'b0, 32'h0);

`ifdef PIPE_CTRL_PERF_EN
    check("perf_loaduse", 64'(perf_loaduse_cnt), 64'd1);
    check("perf_busy", 64'(perf_busy_cnt), 64'd8);
    check("perf_memwait", 64'(perf_memwait_cnt), 64'd1);
    check("perf_redirect", 64'(perf_redirect_cnt), 64'd4);
`endif

    // Reset in the middle of an exception redirect
    next_cycle(); idle(); wb_except_valid = 1; wb_except_target = 32'h1c00c000;
    #1; check_out("rst_exc_n", 5'b00000, 5'b11110, 1'b0, 32'h0);
    next_cycle(); idle();
    #1; check_out("rst_exc_redir", 5'b00000, 5'b11110, 1'b1, 32'h1c00c000);
    next_cycle(); idle(); rst = 1;
    #1; check_out("rst_asserted", 5'b00000, 5'b00000, 1'b0, 32'h0);
    next_cycle(); rst = 0; idle();
    #1; check_out("rst_released", 5'b00000, 5'b00000, 1'b0, 32'h0);
`ifdef PIPE_CTRL_PERF_EN
    check("perf_loaduse_rst", 64'(perf_loaduse_cnt), 64'd0);
    check("perf_busy_rst", 64'(perf_busy_cnt), 64'd0);
    check("perf_memwait_rst", 64'(perf_memwait_cnt), 64'd0);
    check("perf_redirect_rst", 64'(perf_redirect_cnt), 64'd0);
`endif
    next_cycle(); idle(); mem_wait = 1;
    #1; check_out("rst_then_run_rules", 5'b01111, 5'b10000, 1'b0, 32'h0);

    next_cycle(); idle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
